hb_gate_driver: RTL and testbench
=================================

Name: hb_gate_driver

Overview:
- Downstream stage of the hybrid controller: converts the single switching variable sigma into four H-bridge gate commands.
- Inserts a programmable dead time between complementary legs and enforces a minimum on-time per conduction state.
- Provides enable gating and a sticky fault shutdown.
- Sits between the controller's o_sigma and the FPGA gate-driver pins.

Parameters:
CNT_W, 10, width of dead-time / min-on counters and their programming inputs

Ports:
i_clock  in  1  system clock; all logic on rising edge
i_RESET  in  1  synchronous, active-high reset
i_sigma  in  1  switching variable from hybrid controller, same clock domain
i_enable  in  1  1 = bridge may conduct; 0 = all gates off
i_fault  in  1  external fault; latches shutdown
i_deadtime  in  CNT_W  dead interval in clocks (0 treated as 1)
i_min_on  in  CNT_W  minimum cycles in POS/NEG before a new switch is honoured
o_gate  out  4  {Q4,Q3,Q2,Q1}; POS = Q1&Q4 on (4'b1001), NEG = Q2&Q3 on (4'b0110)
o_fault  out  1  sticky fault flag
o_debug  out  16  {state[2:0], sigma_q, fault, 1'b0, cnt[9:0]} (cnt zero-extended/truncated to 10 bits)

Behaviour:
- Reset (i_RESET=1 at a clock edge): state=IDLE, o_gate=0, o_fault=0, cnt=0, sigma_q=0. Reset takes priority over everything, including mid-dead-time and FAULT.
- sigma_q = i_sigma registered once per clock. All decisions use sigma_q, giving 1 cycle of input latency.
- States: IDLE, DEAD, POS, NEG, FAULT (3-bit encoding in shared package).
- o_gate is registered and is a pure function of the state register:
  - POS → 4'b1001
  - NEG → 4'b0110
  - all other states → 0
- Never assert Q1&Q2 or Q3&Q4 simultaneously, in any cycle, including on transitions.
- FAULT:
  - i_fault=1 in any state → next state FAULT and o_fault=1.
  - FAULT is left only by reset.
  - Highest priority after reset.
- Enable:
  - i_enable=0 in any non-FAULT state → next state IDLE.
  - IDLE → DEAD when i_enable=1; load cnt = max(i_deadtime,1).
- DEAD:
  - cnt decrements each clock.
  - When cnt==1, next state = POS if sigma_q=1, else NEG, evaluated in that cycle.
  - The dead interval always completes; sigma_q toggles during DEAD do not restart it.
  - On entering POS/NEG, load cnt = i_min_on.
- POS/NEG:
  - cnt decrements to 0 and holds at 0.
  - If sigma_q differs from the current conduction state and cnt==0 → DEAD, load cnt = max(i_deadtime,1).
  - If it differs while cnt≠0, the switch is deferred. It executes at the first cycle with cnt==0, and only if sigma_q still differs then.
- Dead-time length: exactly max(i_deadtime,1) cycles with o_gate=0 between the last cycle of one conduction state and the first cycle of the other.
- Programming inputs are sampled only at counter-load instants. Changing them mid-interval has no effect on the current interval.
- Counter width is CNT_W unsigned; no wrap. Decrement saturates at 0.
- Total latency from an i_sigma edge to dead-time start (min-on already expired): 2 clocks (sigma register + state register).

Decomposition:
- Shared package hb_pkg:
  - state encodings ST_IDLE=0, ST_DEAD=1, ST_POS=2, ST_NEG=3, ST_FAULT=4
  - gate patterns GATE_POS=4'b1001, GATE_NEG=4'b0110, GATE_OFF=4'b0000
- One natural sub-module, hb_interval_counter: loadable down-counter with saturate-at-zero and a "one" flag, parameterised by CNT_W, reused for dead-time and min-on.

Test Plan:
- Reset then i_enable=1, i_sigma=1, i_deadtime=5, i_min_on=0 → o_gate=0 for 5 cycles after IDLE exit, then 4'b1001.
- In POS, toggle i_sigma to 0 with i_deadtime=5 → o_gate goes 0 two clocks after the edge, stays 0 for exactly 5 cycles, then 4'b0110. Checker verifies no cycle with Q1&Q2 or Q3&Q4.
- i_min_on=20; toggle i_sigma 3 cycles after entering POS → switch deferred. DEAD starts in the cycle after the 20-cycle hold expires.
- i_deadtime=0 → dead interval is exactly 1 cycle. Also: i_sigma pulse 1→0→1 shorter than the dead time → after DEAD, returns to POS.
- Assert i_fault mid-DEAD, then deassert → o_gate=0 and o_fault=1 persist until i_RESET=1, then state=IDLE and o_fault=0.
- Drop i_enable while in NEG → next cycle o_gate=0, state IDLE. Re-enable → full dead interval precedes conduction.

Source files
------------

// File: rtl/hb_gate_driver_pkg.sv
// Shared state encodings and gate patterns for the H-bridge gate driver.
package hb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEAD  = 3'd1,
        ST_POS   = 3'd2,
        ST_NEG   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // Gate bit order is {Q4,Q3,Q2,Q1}
    localparam logic [3:0] GATE_POS = 4'b1001;
    localparam logic [3:0] GATE_NEG = 4'b0110;
    localparam logic [3:0] GATE_OFF = 4'b0000;

    function automatic logic [3:0] gate_of(input state_t s);
        case (s)
            ST_POS:  return GATE_POS;
            ST_NEG:  return GATE_NEG;
            default: return GATE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/hb_gate_driver_if.sv
// Controller-to-driver signal bundle; master drives sigma/enable/programming, slave drives gates.
interface hb_gate_driver_if #(
    parameter int unsigned CNT_W = 10
);
    logic             i_sigma;
    logic             i_enable;
    logic             i_fault;
    logic [CNT_W-1:0] i_deadtime;
    logic [CNT_W-1:0] i_min_on;
    logic [3:0]       o_gate;
    logic             o_fault;
    logic [15:0]      o_debug;

    modport master (
        output i_sigma, i_enable, i_fault, i_deadtime, i_min_on,
        input  o_gate, o_fault, o_debug
    );

    modport slave (
        input  i_sigma, i_enable, i_fault, i_deadtime, i_min_on,
        output o_gate, o_fault, o_debug
    );
endinterface

// File: rtl/hb_gate_driver_counter.sv
// Loadable down-counter that saturates at zero; shared by dead-time and min-on intervals.
module hb_interval_counter #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_one,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_one  = (r_cnt == CNT_W'(1));
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/hb_gate_driver.sv
// Converts switching variable sigma into H-bridge gate commands with dead time,
// minimum on-time, enable gating and sticky fault shutdown.
module hb_gate_driver #(
    parameter int unsigned CNT_W = 10
) (
    input  logic              i_clock,
    input  logic              i_RESET,
    hb_gate_driver_if.slave   bus
);
    import hb_pkg::*;

    state_t           r_state;
    logic [3:0]       r_gate;
    logic             r_fault;
    logic             r_sigma_q;

    state_t           w_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_dead_len;
    logic [CNT_W-1:0] w_cnt;
    logic             w_one;
    logic             w_zero;

    assign w_dead_len = (bus.i_deadtime == '0) ? CNT_W'(1) : bus.i_deadtime;

    hb_interval_counter #(.CNT_W(CNT_W)) u_cnt (
        .i_clk      (i_clock),
        .i_rst      (i_RESET),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_cnt      (w_cnt),
        .o_one      (w_one),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = w_dead_len;
        if (bus.i_fault) begin
            w_next = ST_FAULT;
        end else if (r_state == ST_FAULT) begin
            w_next = ST_FAULT;
        end else if (!bus.i_enable) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next = ST_DEAD;
                    w_load = 1'b1;
                end
                ST_DEAD: begin
                    // Dead interval always runs to completion; direction picked on its last cycle
                    if (w_one) begin
                        w_next     = r_sigma_q ? ST_POS : ST_NEG;
                        w_load     = 1'b1;
                        w_load_val = bus.i_min_on;
                    end
                end
                ST_POS: begin
                    if (!r_sigma_q && w_zero) begin
                        w_next = ST_DEAD;
                        w_load = 1'b1;
                    end
                end
                ST_NEG: begin
                    if (r_sigma_q && w_zero) begin
                        w_next = ST_DEAD;
                        w_load = 1'b1;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Gate register follows the next state so o_gate always matches r_state
    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            r_state   <= ST_IDLE;
            r_gate    <= GATE_OFF;
            r_fault   <= 1'b0;
            r_sigma_q <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_gate    <= gate_of(w_next);
            r_fault   <= r_fault | bus.i_fault;
            r_sigma_q <= bus.i_sigma;
        end
    end

    assign bus.o_gate  = r_gate;
    assign bus.o_fault = r_fault;
    assign bus.o_debug = {r_state, r_sigma_q, r_fault, 1'b0, 10'(w_cnt)};
endmodule

// File: tb/tb_hb_gate_driver.sv
// Directed plus randomized checks of hb_gate_driver against a timeline reference model.
module tb_hb_gate_driver;
    localparam int unsigned CNT_W = 10;

    logic clk;
    logic rst;
    int unsigned n_tests;
    int unsigned n_fail;

    // Reference model: mode 0 idle, 1 dead, 2 conducting, 3 halted by fault
    int   m_mode;
    int   m_dir;
    int   m_timer;
    logic m_sig;
    logic m_fault;

    // Run-length monitor on o_gate
    logic [3:0]  prev_gate;
    int unsigned run_len;
    int unsigned last_zero_len;
    int unsigned last_cond_len;

    hb_gate_driver_if #(.CNT_W(CNT_W)) bus ();

    hb_gate_driver #(.CNT_W(CNT_W)) dut (
        .i_clock (clk),
        .i_RESET (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic s, input logic e, input logic f, input logic r,
                              input int unsigned dt, input int unsigned mo);
        int want;
        int dlen;
        dlen = (dt == 0) ? 1 : int'(dt);
        if (r) begin
            m_mode = 0; m_fault = 1'b0; m_sig = 1'b0; m_timer = 0; m_dir = 0;
        end else begin
            if (f || m_fault) begin
                m_fault = 1'b1;
                m_mode  = 3;
            end else if (!e) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                m_mode = 1; m_timer = dlen;
            end else if (m_mode == 1) begin
                if (m_timer == 1) begin
                    m_mode = 2; m_dir = m_sig ? 1 : -1; m_timer = int'(mo);
                end else begin
                    m_timer = m_timer - 1;
                end
            end else begin
                want = m_sig ? 1 : -1;
                if (want != m_dir && m_timer == 0) begin
                    m_mode = 1; m_timer = dlen;
                end else if (m_timer > 0) begin
                    m_timer = m_timer - 1;
                end
            end
            m_sig = s;
        end
    endtask

    task automatic step(input logic s, input logic e, input logic f, input logic r,
                        input int unsigned dt, input int unsigned mo);
        logic [3:0] exp_gate;
        logic [2:0] exp_state;
        logic [3:0] g;
        bus.i_sigma    = s;
        bus.i_enable   = e;
        bus.i_fault    = f;
        bus.i_deadtime = CNT_W'(dt);
        bus.i_min_on   = CNT_W'(mo);
        rst            = r;
        @(posedge clk);
        model_edge(s, e, f, r, dt, mo);
        #1;
        exp_gate  = (m_mode == 2) ? ((m_dir > 0) ? 4'b1001 : 4'b0110) : 4'b0000;
        exp_state = (m_mode == 0) ? 3'd0 : (m_mode == 1) ? 3'd1 :
                    (m_mode == 3) ? 3'd4 : ((m_dir > 0) ? 3'd2 : 3'd3);
        chk("gate", 32'(bus.o_gate), 32'(exp_gate));
        chk("fault", 32'(bus.o_fault), 32'(m_fault));
        chk("dbg_state", 32'(bus.o_debug[15:13]), 32'(exp_state));
        chk("dbg_flags", 32'(bus.o_debug[12:10]), 32'({m_sig, m_fault, 1'b0}));
        if (m_mode == 1 || m_mode == 2)
            chk("dbg_cnt", 32'(bus.o_debug[9:0]), 32'(m_timer));
        g = bus.o_gate;
        chk("no_shoot_through", 32'((g[0] & g[1]) | (g[2] & g[3])), 32'(0));
        if (g != prev_gate) begin
            if (prev_gate == 4'b0000) last_zero_len = run_len;
            else last_cond_len = run_len;
            run_len = 1;
        end else begin
            run_len++;
        end
        prev_gate = g;
        if (r || !e) run_len = 0;
    endtask

    task automatic run_until_change(input logic s, input logic e, input int unsigned dt,
                                    input int unsigned mo, input int unsigned bound,
                                    input string tag);
        logic [3:0] g0;
        int unsigned n;
        g0 = bus.o_gate;
        n  = 0;
        do begin
            step(s, e, 1'b0, 1'b0, dt, mo);
            n++;
        end while (bus.o_gate == g0 && n < bound);
        chk(tag, 32'(bus.o_gate != g0), 32'(1));
    endtask

    initial begin
        logic s;
        logic e;
        logic f;
        logic r;
        int unsigned dt;
        int unsigned mo;
        n_tests = 0; n_fail = 0;
        m_mode = 0; m_dir = 0; m_timer = 0; m_sig = 1'b0; m_fault = 1'b0;
        prev_gate = 4'b0000; run_len = 0; last_zero_len = 0; last_cond_len = 0;
        rst = 1'b1;
        bus.i_sigma = 1'b0; bus.i_enable = 1'b0; bus.i_fault = 1'b0;
        bus.i_deadtime = '0; bus.i_min_on = '0;

        // Reset state
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("reset_debug", 32'(bus.o_debug), 32'(0));

        // Enable with sigma=1: 5 dead cycles then POS
        run_until_change(1, 1, 5, 0, 20, "first_conduct");
        chk("first_dead_len", last_zero_len, 5);
        chk("first_pos", 32'(bus.o_gate), 32'h9);

        // Toggle to 0: gates off two clocks after edge, 5 dead, then NEG
        step(0, 1, 0, 0, 5, 0);
        chk("lat_1clk_still_pos", 32'(bus.o_gate), 32'h9);
        step(0, 1, 0, 0, 5, 0);
        chk("lat_2clk_off", 32'(bus.o_gate), 32'h0);
        run_until_change(0, 1, 5, 0, 20, "to_neg");
        chk("toggle_dead_len", last_zero_len, 5);
        chk("neg_gate", 32'(bus.o_gate), 32'h6);

        // Min-on 20: toggle 3 cycles after entering POS, switch deferred
        run_until_change(1, 1, 5, 20, 20, "mo_leave_neg");
        run_until_change(1, 1, 5, 20, 20, "mo_enter_pos");
        repeat (3) step(1, 1, 0, 0, 5, 20);
        run_until_change(0, 1, 5, 20, 40, "mo_leave_pos");
        chk("min_on_pos_len", last_cond_len, 21);
        run_until_change(0, 1, 5, 20, 20, "mo_enter_neg");

        // Dead time 0 behaves as 1
        run_until_change(1, 1, 0, 0, 40, "dt0_leave_neg");
        run_until_change(1, 1, 0, 0, 20, "dt0_enter_pos");
        chk("dt0_dead_len", last_zero_len, 1);

        // Short sigma pulse shorter than dead time returns to POS
        step(0, 1, 0, 0, 6, 0);
        step(1, 1, 0, 0, 6, 0);
        chk("pulse_dead_start", 32'(bus.o_gate), 32'h0);
        run_until_change(1, 1, 6, 0, 20, "pulse_return");
        chk("pulse_back_pos", 32'(bus.o_gate), 32'h9);
        chk("pulse_dead_len", last_zero_len, 6);

        // Fault mid-dead: sticky until reset
        step(0, 1, 0, 0, 8, 0);
        step(0, 1, 0, 0, 8, 0);
        step(0, 1, 0, 0, 8, 0);
        step(0, 1, 1, 0, 8, 0);
        repeat (5) step(0, 1, 0, 0, 8, 0);
        chk("fault_held", 32'(bus.o_fault), 32'(1));
        step(0, 1, 0, 1, 8, 0);
        chk("fault_cleared", 32'(bus.o_fault), 32'(0));
        chk("fault_reset_state", 32'(bus.o_debug[15:13]), 32'(0));

        // Enable drop in NEG, then full dead interval on re-enable
        run_until_change(0, 1, 4, 0, 20, "en_to_neg");
        step(0, 0, 0, 0, 4, 0);
        chk("en_drop_gate", 32'(bus.o_gate), 32'h0);
        chk("en_drop_idle", 32'(bus.o_debug[15:13]), 32'(0));
        repeat (3) step(0, 0, 0, 0, 4, 0);
        run_until_change(0, 1, 4, 0, 20, "reenable");
        chk("reenable_dead_len", last_zero_len, 4);

        // Randomized traffic
        s = 1'b0; dt = 3; mo = 2;
        for (int i = 0; i < 600; i++) begin
            if (($urandom % 6) == 0) s = ~s;
            e = (($urandom % 50) != 0);
            f = (($urandom % 150) == 0);
            r = (($urandom % 60) == 0);
            if (($urandom % 10) == 0) dt = $urandom % 8;
            if (($urandom % 10) == 0) mo = $urandom % 12;
            step(s, e, f, r, dt, mo);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
